// File: rtl/dense_layer_mac.sv
// dense_layer_mac
// Multi-image dense-layer engine. A shared weight is broadcast to N_CH pixel
// lanes each cycle, and every lane builds a signed fixed-point dot product of
// VEC_LEN terms. At the end of a vector the bias is folded in, the sum is
// rescaled, saturated and optionally ReLU-clamped, and one result per lane is
// offered downstream with a ready/valid handshake.
module dense_layer_mac #(
    parameter int  N_CH      = 10,
    parameter int  DATA_W    = 16,
    parameter int  FRAC_BITS = 8,
    parameter int  VEC_LEN   = 784,
    parameter int  NUM_OUT   = 200,
    parameter int  RELU_EN   = 1,
    localparam int ACC_W     = 2*DATA_W + $clog2(VEC_LEN) + 1,
    localparam int IDX_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*DATA_W-1:0]   pixels,
    input  logic [DATA_W-1:0]        weight,
    input  logic [DATA_W-1:0]        bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic [N_CH-1:0]          out_sat
);

    localparam int PROD_W = 2*DATA_W;
    localparam int CNT_W  = $clog2(VEC_LEN);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    // Output range expressed at accumulator width so the clip test is a plain
    // signed comparison against the rescaled sum.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Term counter
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       accept;

    // Stage 1: registered products and vector position flags
    logic                       s1_valid_q;
    logic                       s1_first_q;
    logic                       s1_last_q;
    logic signed [PROD_W-1:0]   s1_prod_q [N_CH];
    logic signed [DATA_W-1:0]   s1_bias_q;
    logic signed [PROD_W-1:0]   prod_d    [N_CH];

    // Stage 2: accumulators and the "vector complete" flag
    logic signed [ACC_W-1:0]    acc_q     [N_CH];
    logic signed [ACC_W-1:0]    acc_d     [N_CH];
    logic                       fin_q;

    // Finalised lane results derived from the completed accumulators
    logic [N_CH*DATA_W-1:0]     res_data;
    logic [N_CH-1:0]            res_sat;

    // Output register and neuron counter
    logic                       out_valid_q, out_valid_d;
    logic [N_CH*DATA_W-1:0]     out_data_q,  out_data_d;
    logic [IDX_W-1:0]           out_idx_q,   out_idx_d;
    logic [N_CH-1:0]            out_sat_q,   out_sat_d;
    logic [IDX_W-1:0]           nidx_q,      nidx_d;

    // Only the final term of a vector can stall: it would finalise into an
    // output register still holding an unconsumed result.
    assign in_ready = !((cnt_q == LAST_CNT) && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready && !clear;

    // Next term position: wraps after the last term, flushed by clear
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Term position tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Full-width signed product of each lane pixel with the shared weight
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            prod_d[k] = PROD_W'($signed(pixels[k*DATA_W +: DATA_W])) *
                        PROD_W'($signed(weight));
        end
    end

    // Stage 1: capture products, vector position and (on the first term) bias
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bias_q  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                s1_prod_q[k] <= '0;
            end
        end else if (clear) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_first_q <= (cnt_q == '0);
                s1_last_q  <= (cnt_q == LAST_CNT);
                if (cnt_q == '0) begin
                    s1_bias_q <= $signed(bias);
                end
                for (int k = 0; k < N_CH; k++) begin
                    s1_prod_q[k] <= prod_d[k];
                end
            end
        end
    end

    // Accumulator update: the first term seeds the sum with the scaled bias
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            if (s1_first_q) begin
                acc_d[k] = (ACC_W'(s1_bias_q) <<< FRAC_BITS) + ACC_W'(s1_prod_q[k]);
            end else begin
                acc_d[k] = acc_q[k] + ACC_W'(s1_prod_q[k]);
            end
        end
    end

    // Stage 2: running sums plus a flag marking a completed vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fin_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                acc_q[k] <= '0;
            end
        end else if (clear) begin
            fin_q <= 1'b0;
        end else begin
            fin_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                for (int k = 0; k < N_CH; k++) begin
                    acc_q[k] <= acc_d[k];
                end
            end
        end
    end

    // Rescale (floor), saturate and optionally ReLU-clamp each lane
    always_comb begin
        logic signed [ACC_W-1:0] shifted;
        logic [DATA_W-1:0]       lane_val;
        logic                    lane_sat;
        res_data = '0;
        res_sat  = '0;
        shifted  = '0;
        lane_val = '0;
        lane_sat = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            shifted  = acc_q[k] >>> FRAC_BITS;
            lane_val = shifted[DATA_W-1:0];
            lane_sat = 1'b0;
            if (shifted > SAT_MAX) begin
                lane_val = SAT_MAX[DATA_W-1:0];
                lane_sat = 1'b1;
            end else if (shifted < SAT_MIN) begin
                lane_val = SAT_MIN[DATA_W-1:0];
                lane_sat = 1'b1;
            end
            if ((RELU_EN != 0) && lane_val[DATA_W-1]) begin
                lane_val = '0;
                lane_sat = 1'b0;
            end
            res_data[k*DATA_W +: DATA_W] = lane_val;
            res_sat[k]                   = lane_sat;
        end
    end

    // Output register: load a finished vector, otherwise drain on handshake.
    // A load in the same cycle as a handshake replaces the consumed result.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_sat_d   = out_sat_q;
        nidx_d      = nidx_q;
        if (fin_q && !clear) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_sat_d   = res_sat;
            out_idx_d   = nidx_q;
            nidx_d      = (nidx_q == LAST_IDX) ? '0 : nidx_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            nidx_d = '0;
        end
    end

    // Output register and neuron counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_sat_q   <= '0;
            nidx_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_sat_q   <= out_sat_d;
            nidx_q      <= nidx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dense_layer_mac.sv
// tb_dense_layer_mac
// Two engines (ReLU on and off) share one stimulus stream. A transaction-level
// model predicts in_ready and the output register every cycle; directed
// sections pin the model with hand-computed results.
module tb_dense_layer_mac;

    localparam int N_CH      = 2;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int VEC_LEN   = 4;
    localparam int NUM_OUT   = 3;

    logic        clk      = 1'b0;
    logic        rstN     = 1'b1;
    logic        clear    = 1'b0;
    logic        inValid  = 1'b0;
    logic        outReady = 1'b1;
    logic [31:0] pixels   = '0;
    logic [15:0] weight   = '0;
    logic [15:0] bias     = '0;

    logic        inReadyR, inReadyN, outValidR, outValidN;
    logic [31:0] outDataR, outDataN;
    logic [1:0]  outIdxR, outIdxN, outSatR, outSatN;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        int          due;
        logic [31:0] dR;
        logic [31:0] dN;
        logic [1:0]  sR;
        logic [1:0]  sN;
    } res_t;

    typedef struct {
        logic [31:0] dR;
        logic [31:0] dN;
        logic [1:0]  sR;
        logic [1:0]  sN;
        logic [1:0]  idx;
        int          at;
    } hs_t;

    // Model state: term position, per-lane exact sums, results in flight and
    // the expected contents of the output register
    int          edgeCnt = 0;
    int          cntM    = 0;
    int          nIdxM   = 0;
    longint      sumM [N_CH];
    res_t        pendQ [$];
    res_t        newRes;
    hs_t         hsLog [$];
    logic        accM;
    logic        expReady;
    logic        expValid = 1'b0;
    logic [31:0] expDataR = '0;
    logic [31:0] expDataN = '0;
    logic [1:0]  expSatR  = '0;
    logic [1:0]  expSatN  = '0;
    logic [1:0]  expIdx   = '0;
    logic [15:0] vR, vN;
    logic        sRb, sNb;

    dense_layer_mac #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS),
        .VEC_LEN(VEC_LEN), .NUM_OUT(NUM_OUT), .RELU_EN(1)
    ) dutRelu (
        .clk(clk), .reset(rstN), .clear(clear),
        .in_valid(inValid), .in_ready(inReadyR),
        .pixels(pixels), .weight(weight), .bias(bias),
        .out_valid(outValidR), .out_ready(outReady),
        .out_data(outDataR), .out_idx(outIdxR), .out_sat(outSatR)
    );

    dense_layer_mac #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS),
        .VEC_LEN(VEC_LEN), .NUM_OUT(NUM_OUT), .RELU_EN(0)
    ) dutLin (
        .clk(clk), .reset(rstN), .clear(clear),
        .in_valid(inValid), .in_ready(inReadyN),
        .pixels(pixels), .weight(weight), .bias(bias),
        .out_valid(outValidN), .out_ready(outReady),
        .out_data(outDataN), .out_idx(outIdxN), .out_sat(outSatN)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // The final term stalls only while an unconsumed result is waiting
    assign expReady = !((cntM == VEC_LEN - 1) && expValid && !outReady);

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Rescale a finished sum by flooring, clip to 16 bits, and derive both the
    // ReLU and the linear view of the result
    function automatic void finalise(input longint acc,
                                     output logic [15:0] valRelu, output logic satRelu,
                                     output logic [15:0] valLin,  output logic satLin);
        longint r;
        r = acc >>> FRAC_BITS;
        if (r > 32767) begin
            valLin = 16'h7FFF;
            satLin = 1'b1;
        end else if (r < -32768) begin
            valLin = 16'h8000;
            satLin = 1'b1;
        end else begin
            valLin = 16'(r);
            satLin = 1'b0;
        end
        if (r < 0) begin
            valRelu = 16'h0000;
            satRelu = 1'b0;
        end else begin
            valRelu = valLin;
            satRelu = satLin;
        end
    endfunction

    // Random operand: mostly small values around zero, sometimes full range
    function automatic logic [15:0] randVal();
        if ($urandom_range(0, 3) == 0) begin
            return 16'($urandom);
        end
        return 16'(int'($urandom_range(0, 2047)) - 1024);
    endfunction

    // Behavioural model: on each edge retire a due result into the output
    // register or drain it, apply clear, then fold in an accepted term and
    // schedule the finished vector two edges later
    initial begin
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                cntM     = 0;
                nIdxM    = 0;
                expValid = 1'b0;
                expDataR = '0;
                expDataN = '0;
                expSatR  = '0;
                expSatN  = '0;
                expIdx   = '0;
                pendQ.delete();
            end else begin
                edgeCnt++;
                accM = inValid && expReady && !clear;
                if (pendQ.size() > 0 && pendQ[0].due == edgeCnt && !clear) begin
                    expValid = 1'b1;
                    expDataR = pendQ[0].dR;
                    expDataN = pendQ[0].dN;
                    expSatR  = pendQ[0].sR;
                    expSatN  = pendQ[0].sN;
                    expIdx   = 2'(nIdxM);
                    nIdxM    = (nIdxM + 1) % NUM_OUT;
                    void'(pendQ.pop_front());
                end else if (expValid && outReady) begin
                    expValid = 1'b0;
                end
                if (clear) begin
                    pendQ.delete();
                    cntM  = 0;
                    nIdxM = 0;
                end
                if (accM) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (cntM == 0) begin
                            sumM[k] = longint'($signed(bias)) * 256;
                        end
                        sumM[k] += longint'($signed(pixels[k*16 +: 16])) * longint'($signed(weight));
                    end
                    if (cntM == VEC_LEN - 1) begin
                        newRes.due = edgeCnt + 2;
                        for (int k = 0; k < N_CH; k++) begin
                            finalise(sumM[k], vR, sRb, vN, sNb);
                            newRes.dR[k*16 +: 16] = vR;
                            newRes.dN[k*16 +: 16] = vN;
                            newRes.sR[k]          = sRb;
                            newRes.sN[k]          = sNb;
                        end
                        pendQ.push_back(newRes);
                        cntM = 0;
                    end else begin
                        cntM++;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, and a log of every handshake so
    // directed sections can inspect results in order
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("inReadyRelu",  64'(inReadyR),  64'(expReady));
            checkOutput("inReadyLin",   64'(inReadyN),  64'(expReady));
            checkOutput("outValidRelu", 64'(outValidR), 64'(expValid));
            checkOutput("outValidLin",  64'(outValidN), 64'(expValid));
            if (expValid) begin
                checkOutput("outDataRelu", 64'(outDataR), 64'(expDataR));
                checkOutput("outDataLin",  64'(outDataN), 64'(expDataN));
                checkOutput("outSatRelu",  64'(outSatR),  64'(expSatR));
                checkOutput("outSatLin",   64'(outSatN),  64'(expSatN));
                checkOutput("outIdxRelu",  64'(outIdxR),  64'(expIdx));
                checkOutput("outIdxLin",   64'(outIdxN),  64'(expIdx));
            end
            if (outValidR && outReady) begin
                hsLog.push_back('{outDataR, outDataN, outSatR, outSatN, outIdxR, edgeCnt});
            end
        end
    end

    // Present one term and hold it until accepted (bounded wait)
    task automatic applyStimulus(input logic [15:0] p0, input logic [15:0] p1,
                                 input logic [15:0] w,  input logic [15:0] b);
        int guard;
        guard   = 0;
        pixels  = {p1, p0};
        weight  = w;
        bias    = b;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReadyR && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!inReadyR) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL termAccept: in_ready 0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // One-cycle clear, optionally with a junk term that must be ignored
    task automatic doClear(input logic junkValid);
        clear   = 1'b1;
        inValid = junkValid;
        pixels  = 32'hDEAD_BEEF;
        weight  = 16'h1234;
        bias    = 16'h4321;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        inValid = 1'b0;
    endtask

    // Hard stop in case something never returns
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sections followed by a randomized soak
    initial begin
        int idxExp [4];
        idxExp = '{0, 1, 2, 0};

        #1 rstN = 1'b0;
        #20 rstN = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a vector with a result pending
        outReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("preResetValid", 64'(outValidR), 64'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rstInReady",  64'(inReadyR),  64'd1);
        checkOutput("rstOutValid", 64'(outValidR), 64'd0);
        checkOutput("rstOutData",  64'(outDataR),  64'd0);
        checkOutput("rstOutIdx",   64'(outIdxR),   64'd0);
        checkOutput("rstOutSat",   64'(outSatR),   64'd0);
        #2 rstN = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        hsLog.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("resumeCount", 64'(hsLog.size()), 64'd1);
        if (hsLog.size() > 0) begin
            checkOutput("resumeData", 64'(hsLog[0].dR),  64'h0500_0500);
            checkOutput("resumeIdx",  64'(hsLog[0].idx), 64'd0);
        end

        // Arithmetic and latency: 4 x (1.0 * 2.0) + 0.5 = 8.5
        doClear(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0100, 16'h0100, 16'h0200, 16'h0080);
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("latencyEarly", 64'(outValidR), 64'd0);
        @(negedge clk);
        checkOutput("latencyValid", 64'(outValidR), 64'd1);
        checkOutput("arithData",    64'(outDataR),  64'h0880_0880);
        checkOutput("arithIdx",     64'(outIdxR),   64'd0);
        checkOutput("arithSat",     64'(outSatR),   64'd0);
        @(posedge clk);
        #1;

        // Saturation high on lane 0, saturation low on lane 1
        doClear(1'b0);
        hsLog.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h7FFF, 16'h8001, 16'h7FFF, 16'h0000);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("satCount", 64'(hsLog.size()), 64'd1);
        if (hsLog.size() > 0) begin
            checkOutput("satDataRelu", 64'(hsLog[0].dR), 64'h0000_7FFF);
            checkOutput("satFlagRelu", 64'(hsLog[0].sR), 64'b01);
            checkOutput("satDataLin",  64'(hsLog[0].dN), 64'h8000_7FFF);
            checkOutput("satFlagLin",  64'(hsLog[0].sN), 64'b11);
        end

        // Backpressure across two vectors; only the second final term stalls
        doClear(1'b0);
        hsLog.delete();
        outReady = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    applyStimulus(16'h0100, 16'h0200, 16'h0100, 16'h0000);
                end
                for (int i = 0; i < 4; i++) begin
                    applyStimulus(16'h0100, 16'h0200, 16'h0080, 16'h0000);
                end
            end
            begin
                int guard;
                guard = 0;
                @(negedge clk);
                while (inReadyR && guard < 60) begin
                    @(negedge clk);
                    guard++;
                end
                checkOutput("bpStall", 64'(inReadyR), 64'd0);
                repeat (2) begin
                    @(negedge clk);
                    checkOutput("bpHold", 64'(inReadyR), 64'd0);
                end
                @(posedge clk);
                #1 outReady = 1'b1;
                @(posedge clk);
                #1 outReady = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bpPendingCount", 64'(hsLog.size()), 64'd1);
        checkOutput("bpPendingValid", 64'(outValidR),    64'd1);
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bpCount", 64'(hsLog.size()), 64'd2);
        if (hsLog.size() >= 2) begin
            checkOutput("bpData0", 64'(hsLog[0].dR),  64'h0800_0400);
            checkOutput("bpIdx0",  64'(hsLog[0].idx), 64'd0);
            checkOutput("bpData1", 64'(hsLog[1].dR),  64'h0400_0200);
            checkOutput("bpIdx1",  64'(hsLog[1].idx), 64'd1);
        end

        // Clear part-way through a vector, with a junk term during clear
        doClear(1'b0);
        hsLog.delete();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(16'h0300, 16'h0300, 16'h0300, 16'h0300);
        end
        doClear(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0100, 16'h0100, 16'h0100, 16'h0000);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("clrCount", 64'(hsLog.size()), 64'd1);
        if (hsLog.size() > 0) begin
            checkOutput("clrData", 64'(hsLog[0].dR),  64'h0400_0400);
            checkOutput("clrIdx",  64'(hsLog[0].idx), 64'd0);
        end

        // Neuron index wrap over four back-to-back vectors
        doClear(1'b0);
        hsLog.delete();
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(16'h0100, 16'h0100, 16'((v + 1) * 256), 16'h0000);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("wrapCount", 64'(hsLog.size()), 64'd4);
        if (hsLog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("wrapIdx",  64'(hsLog[i].idx),     64'(idxExp[i]));
                checkOutput("wrapData", 64'(hsLog[i].dR[15:0]), 64'((i + 1) * 1024));
                if (i > 0) begin
                    checkOutput("wrapSpacing", 64'(hsLog[i].at - hsLog[i-1].at), 64'd4);
                end
            end
        end

        // Randomized soak with random backpressure and occasional clears
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            inValid  = ($urandom_range(0, 3) != 0);
            pixels   = {randVal(), randVal()};
            weight   = randVal();
            bias     = randVal();
            outReady = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        clear    = 1'b0;
        outReady = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
